fifo_rd_arbiter: RTL

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_rd_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_rd_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO read-port arbiter.
package fifo_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DSIZE_DEF     = 8;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after
// rr_ptr (wrapping) wins; returns its one-hot, its index and whether any won.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   index,
    output logic            any
);

    localparam int IW1 = IW + 1;

    logic [NREQ-1:0] rotated;
    logic [IW-1:0]   rot_idx [NREQ];

    // rotated[gi] is the request sitting gi places after rr_ptr
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IW1-1:0] sum;
            assign sum         = {1'b0, rr_ptr} + IW1'(gi);
            assign rot_idx[gi] = (sum >= IW1'(NREQ)) ? IW'(sum - IW1'(NREQ)) : IW'(sum);
            assign rotated[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        index  = '0;
        winner = '0;
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                index = rot_idx[k];
            end
        end
        winner[index] = any;
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NREQ requesters.
// Define FIFO_RD_ARB_BURST_EN to let a grant hold for up to BURST_LEN pops.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int DSIZE     = DSIZE_DEF,
    parameter  int BURST_LEN = BURST_LEN_DEF,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    output logic [IW-1:0]    dout_id
);

`ifdef FIFO_RD_ARB_BURST_EN
    localparam int EFF_BURST = BURST_LEN;
`else
    localparam int EFF_BURST = 1;
`endif
    localparam int CW  = $clog2(BURST_LEN + 1);
    localparam int IW1 = IW + 1;

    arb_state_e      state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [DSIZE-1:0] dout_reg;
    logic            dout_valid_reg;
    logic [IW-1:0]   dout_id_reg;

    logic [NREQ-1:0] pick_winner;
    logic [IW-1:0]   pick_index;
    logic            pick_any;
    logic            granted_req;
    logic            rinc_int;
    logic [CW-1:0]   count_inc;
    logic            last_pop;
    logic [IW1-1:0]  ptr_sum;
    logic [IW-1:0]   ptr_after;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (pick_winner),
        .index  (pick_index),
        .any    (pick_any)
    );

    // Only the granted requester's line matters once a grant is live
    assign granted_req = |(req & gnt_reg);
    assign rinc_int    = (state_reg == GRANT) && granted_req && !rempty;
    assign count_inc   = count_reg + CW'(1);
    assign last_pop    = rinc_int && (count_inc == CW'(EFF_BURST));
    assign ptr_sum     = {1'b0, idx_reg} + IW1'(1);
    assign ptr_after   = (ptr_sum >= IW1'(NREQ)) ? '0 : ptr_sum[IW-1:0];

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        idx_next    = idx_reg;
        rr_ptr_next = rr_ptr_reg;
        count_next  = count_reg;
        case (state_reg)
            IDLE: begin
                gnt_next = '0;
                if (pick_any && !rempty) begin
                    state_next = GRANT;
                    gnt_next   = pick_winner;
                    idx_next   = pick_index;
                    count_next = '0;
                end
            end
            GRANT: begin
                if (rinc_int) begin
                    count_next = count_inc;
                end
                // Always drop to IDLE so a waiting requester gets its turn
                if (!granted_req || last_pop) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    rr_ptr_next = ptr_after;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            idx_reg    <= '0;
            rr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            idx_reg    <= idx_next;
            rr_ptr_reg <= rr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // A word popped on a reset edge is dropped rather than presented
    always_ff @(posedge rclk) begin
        if (rrst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            dout_id_reg    <= '0;
        end else begin
            dout_valid_reg <= rinc_int;
            if (rinc_int) begin
                dout_reg    <= rdata;
                dout_id_reg <= idx_reg;
            end
        end
    end

    assign rinc       = rinc_int;
    assign gnt        = gnt_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_id    = dout_id_reg;

endmodule
